// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
// No timing of its own; holds FSM states, funct3 encodings and size/alignment helpers.
package mem_access_unit_pkg;

  localparam int DataBusBits = 64;
  localparam logic [DataBusBits-1:0] DataZero = '0;

  typedef enum logic [1:0] {
    MauIdle = 2'd0,
    MauReq  = 2'd1,
    MauWait = 2'd2,
    MauDone = 2'd3
  } mau_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic access_aligned(input logic [2:0] f3, input logic [2:0] off);
    logic ok;
    case (f3[1:0])
      2'd0:    ok = 1'b1;
      2'd1:    ok = ~off[0];
      2'd2:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load formatter: extracts the addressed lane of an aligned doubleword and sign/zero-extends it.
// Purely combinational; no handshake.
module load_formatter
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DataBusBits
) (
  input  logic [DATA_W-1:0] rsp_rdata,
  input  logic [2:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] lane;

  assign lane = rsp_rdata >> {off, 3'b000};

  always_comb begin
    data = lane;
    case (funct3)
      F3_B:    data = {{(DATA_W-8){lane[7]}},   lane[7:0]};
      F3_H:    data = {{(DATA_W-16){lane[15]}}, lane[15:0]};
      F3_W:    data = {{(DATA_W-32){lane[31]}}, lane[31:0]};
      F3_BU:   data = {{(DATA_W-8){1'b0}},      lane[7:0]};
      F3_HU:   data = {{(DATA_W-16){1'b0}},     lane[15:0]};
      F3_WU:   data = {{(DATA_W-32){1'b0}},     lane[31:0]};
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding valid/ready request; load 3 / store 2 stall cycles at zero wait.
// req_ready low holds REQ with fields stable; rsp_valid low holds WAIT; pipeline stalled throughout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DataBusBits,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic              stall,
  output logic [DATA_W-1:0] readData,
  output logic              misaligned,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic [STRB_W-1:0] req_wstrb,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_rdata
);

  mau_state_t        state_q, state_d;
  logic [2:0]        f3_q;
  logic [2:0]        off_q;
  logic              acc;
  logic              aligned;
  logic              latch;
  logic              load_rsp;
  logic [DATA_W-1:0] fmt_data;

  assign acc     = mem_valid & (memRead | memWrite);
  assign aligned = access_aligned(funct3, addr[2:0]);

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    misaligned = 1'b0;
    req_valid  = 1'b0;
    latch      = 1'b0;
    load_rsp   = 1'b0;
    case (state_q)
      MauIdle: begin
        if (acc) begin
          if (aligned) begin
            stall   = 1'b1;
            latch   = 1'b1;
            state_d = MauReq;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      MauReq: begin
        req_valid = 1'b1;
        stall     = 1'b1;
        if (req_ready) state_d = req_we ? MauDone : MauWait;
      end
      MauWait: begin
        stall = 1'b1;
        if (rsp_valid) begin
          load_rsp = 1'b1;
          state_d  = MauDone;
        end
      end
      MauDone: state_d = MauIdle;
      default: state_d = MauIdle;
    endcase
  end

  // Load wins when both memRead and memWrite are set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= MauIdle;
      req_we    <= 1'b0;
      req_addr  <= DataZero;
      req_wdata <= DataZero;
      req_wstrb <= '0;
      f3_q      <= 3'b000;
      off_q     <= 3'b000;
      readData  <= DataZero;
    end else begin
      state_q <= state_d;
      if (latch) begin
        req_we    <= ~memRead;
        req_addr  <= {addr[DATA_W-1:3], 3'b000};
        req_wdata <= memRead ? DataZero : (writeData << {addr[2:0], 3'b000});
        req_wstrb <= memRead ? '0 : STRB_W'(size_mask(funct3[1:0]) << addr[2:0]);
        f3_q      <= funct3;
        off_q     <= addr[2:0];
      end
      if (load_rsp) readData <= fmt_data;
    end
  end

  load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
    .rsp_rdata (rsp_rdata),
    .off       (off_q),
    .funct3    (f3_q),
    .data      (fmt_data)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected results queued at stimulus time, popped on completion.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, memRead, memWrite;
  logic [2:0]  funct3;
  logic [63:0] addr, writeData;
  logic        stall;
  logic [63:0] readData;
  logic        misaligned;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_rd = 64'h0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [7:0]  wstrb;
    logic        we;
    logic        mis;
    int          stalls;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(64), .STRB_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_valid  (mem_valid),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .funct3     (funct3),
    .addr       (addr),
    .writeData  (writeData),
    .stall      (stall),
    .readData   (readData),
    .misaligned (misaligned),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata)
  );

  // Reference behaviour built byte by byte, independent of the RTL formatter.
  task automatic push_exp(input logic rd, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input logic [63:0] rdat,
                          input int rdy_delay, input int rsp_delay);
    exp_t e;
    int n, off;
    logic [63:0] r;
    n = 1 << f3[1:0];
    off = int'(a[2:0]);
    e.mis = (off % n) != 0;
    e.we = !rd;
    e.addr = {a[63:3], 3'b000};
    e.wstrb = 8'h00;
    e.wdata = 64'h0;
    if (!rd) begin
      for (int i = 0; i < n; i++) e.wstrb[off + i] = 1'b1;
      e.wdata = wd << (8 * off);
    end
    r = 64'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rdat[8*(off + i) +: 8];
    if (!f3[2]) for (int i = 8 * n; i < 64; i++) r[i] = r[8*n - 1];
    if (e.mis) e.stalls = 0;
    else if (rd) e.stalls = 3 + rdy_delay + rsp_delay;
    else e.stalls = 2 + rdy_delay;
    if (rd && !e.mis) last_rd = r;
    e.rdata = last_rd;
    exp_q.push_back(e);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0;
  endtask

  // Drives one instruction in MEM, acts as the memory, and scores the result on completion.
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                           input int rdy_delay, input int rsp_delay);
    int stalls, mis_cnt, reqs, req_seen, wait_seen;
    logic accepted, rsp_done, done, stable, c_we;
    logic [63:0] c_addr, c_wdata, got_rd;
    logic [7:0] c_wstrb;
    exp_t e;
    stalls = 0; mis_cnt = 0; reqs = 0; req_seen = 0; wait_seen = 0;
    accepted = 1'b0; rsp_done = 1'b0; done = 1'b0; stable = 1'b1;
    c_we = 1'b0; c_addr = 64'h0; c_wdata = 64'h0; c_wstrb = 8'h0; got_rd = 64'h0;
    @(posedge clk); #1;
    mem_valid = 1'b1; memRead = rd; memWrite = wr; funct3 = f3; addr = a; writeData = wd;
    req_ready = (rdy_delay == 0); rsp_valid = 1'b0; rsp_rdata = 64'h0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (misaligned) mis_cnt++;
      if (req_valid) begin
        if (req_seen == 0) begin
          c_addr = req_addr; c_wdata = req_wdata; c_wstrb = req_wstrb; c_we = req_we;
        end else if (req_addr !== c_addr || req_wdata !== c_wdata ||
                     req_wstrb !== c_wstrb || req_we !== c_we) begin
          stable = 1'b0;
        end
        req_seen++;
        if (req_ready) begin accepted = 1'b1; reqs++; end
      end
      if (!stall) begin
        got_rd = readData;
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      req_ready = (req_seen >= rdy_delay);
      if (accepted && !c_we && !rsp_done) begin
        rsp_valid = (wait_seen >= rsp_delay);
        rsp_rdata = rsp_valid ? rdat : ~rdat;
        if (rsp_valid) rsp_done = 1'b1;
        wait_seen++;
      end else if (!accepted && !req_ready && req_seen > 0) begin
        rsp_valid = 1'b1;
        rsp_rdata = ~rdat;
      end else begin
        rsp_valid = 1'b0;
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL %s timeout got=no_completion exp=completion", name); end
    checks++;
    if (stalls != e.stalls) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, e.stalls); end
    checks++;
    if (mis_cnt != (e.mis ? 1 : 0)) begin failures++; $display("FAIL %s misaligned_cycles got=%0d exp=%0d", name, mis_cnt, e.mis ? 1 : 0); end
    checks++;
    if (reqs != (e.mis ? 0 : 1)) begin failures++; $display("FAIL %s requests got=%0d exp=%0d", name, reqs, e.mis ? 0 : 1); end
    if (!e.mis) begin
      checks++;
      if (c_addr !== e.addr) begin failures++; $display("FAIL %s req_addr got=%h exp=%h", name, c_addr, e.addr); end
      checks++;
      if (c_we !== e.we) begin failures++; $display("FAIL %s req_we got=%b exp=%b", name, c_we, e.we); end
      checks++;
      if (c_wstrb !== e.wstrb) begin failures++; $display("FAIL %s req_wstrb got=%h exp=%h", name, c_wstrb, e.wstrb); end
      checks++;
      if (stable !== 1'b1) begin failures++; $display("FAIL %s req_stable got=unstable exp=stable", name); end
      if (e.we) begin
        checks++;
        if (c_wdata !== e.wdata) begin failures++; $display("FAIL %s req_wdata got=%h exp=%h", name, c_wdata, e.wdata); end
      end
    end
    checks++;
    if (got_rd !== e.rdata) begin failures++; $display("FAIL %s readData got=%h exp=%h", name, got_rd, e.rdata); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'b0;
    addr = 64'h0; writeData = 64'h0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'h0;
    #12;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", req_valid); end
    checks++; if (req_we !== 1'b0) begin failures++; $display("FAIL reset_req_we got=%b exp=0", req_we); end
    checks++; if (req_wstrb !== 8'h0) begin failures++; $display("FAIL reset_req_wstrb got=%h exp=0", req_wstrb); end
    checks++; if (req_addr !== 64'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
    checks++; if (req_wdata !== 64'h0) begin failures++; $display("FAIL reset_req_wdata got=%h exp=0", req_wdata); end
    checks++; if (readData !== 64'h0) begin failures++; $display("FAIL reset_readData got=%h exp=0", readData); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", misaligned); end
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 64'h0;
  endtask

  task automatic test_ld();
    push_exp(1'b1, 3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0);
    do_access("ld_1000", 1'b1, 1'b0, 3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0);
    go_idle();
  endtask

  task automatic test_lb_lbu();
    push_exp(1'b1, 3'b000, 64'h1003, 64'h0, 64'h00000000_80FF0000, 0, 0);
    do_access("lb_1003", 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h00000000_80FF0000, 0, 0);
    go_idle();
    push_exp(1'b1, 3'b100, 64'h1003, 64'h0, 64'h00000000_80FF0000, 0, 0);
    do_access("lbu_1003", 1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 64'h00000000_80FF0000, 0, 0);
    go_idle();
  endtask

  task automatic test_sh();
    push_exp(1'b0, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 0);
    do_access("sh_2006", 1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 0);
    go_idle();
  endtask

  task automatic test_misaligned();
    push_exp(1'b1, 3'b010, 64'h3002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    do_access("lw_3002_misaligned", 1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    push_exp(1'b0, 3'b011, 64'h3004, 64'h55, 64'h0, 0, 0);
    do_access("sd_3004_misaligned", 1'b0, 1'b1, 3'b011, 64'h3004, 64'h55, 64'h0, 0, 0);
    go_idle();
  endtask

  task automatic test_backpressure();
    push_exp(1'b1, 3'b110, 64'h5004, 64'h0, 64'h8765_4321_DEAD_BEEF, 5, 4);
    do_access("lwu_bp", 1'b1, 1'b0, 3'b110, 64'h5004, 64'h0, 64'h8765_4321_DEAD_BEEF, 5, 4);
    go_idle();
    push_exp(1'b0, 3'b010, 64'h5104, 64'h1234_5678, 64'h0, 3, 0);
    do_access("sw_bp", 1'b0, 1'b1, 3'b010, 64'h5104, 64'h1234_5678, 64'h0, 3, 0);
    go_idle();
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 3'b011, 64'h6000, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 0, 0);
    do_access("b2b_sd", 1'b0, 1'b1, 3'b011, 64'h6000, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 0, 0);
    push_exp(1'b1, 3'b001, 64'h600A, 64'h0, 64'h0000_8001_0000_0000, 0, 1);
    do_access("b2b_lh", 1'b1, 1'b0, 3'b001, 64'h600A, 64'h0, 64'h0000_8001_0000_0000, 0, 1);
    push_exp(1'b1, 3'b010, 64'h6010, 64'hFFFF, 64'hFFFF_FFFF_7FFF_FFFF, 0, 0);
    do_access("b2b_rw_as_load", 1'b1, 1'b1, 3'b010, 64'h6010, 64'hFFFF, 64'hFFFF_FFFF_7FFF_FFFF, 0, 0);
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic rd;
      logic [2:0] f3;
      logic [63:0] a, wd, rdat;
      int n, rdy, rspd;
      rd = 1'($urandom_range(0, 1));
      f3 = rd ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
      n = 1 << f3[1:0];
      a = {$urandom, $urandom};
      a[2:0] = 3'(($urandom_range(0, 7) / n) * n);
      wd = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rdy = $urandom_range(0, 2);
      rspd = $urandom_range(0, 2);
      push_exp(rd, f3, a, wd, rdat, rdy, rspd);
      do_access($sformatf("rand_%0d", i), rd, !rd, f3, a, wd, rdat, rdy, rspd);
    end
    go_idle();
  endtask

  task automatic test_reset_in_wait();
    @(posedge clk); #1;
    mem_valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; funct3 = 3'b011;
    addr = 64'h7008; req_ready = 1'b1; rsp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rst_wait_stall_before got=%b exp=1", stall); end
    #2;
    reset_n = 1'b0;
    mem_valid = 1'b0; memRead = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_wait_req_valid got=%b exp=0", req_valid); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_wait_stall got=%b exp=0", stall); end
    checks++; if (req_addr !== 64'h0) begin failures++; $display("FAIL rst_wait_req_addr got=%h exp=0", req_addr); end
    checks++; if (readData !== 64'h0) begin failures++; $display("FAIL rst_wait_readData got=%h exp=0", readData); end
    last_rd = 64'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++; if (readData !== 64'h0) begin failures++; $display("FAIL rst_wait_stray_rsp_readData got=%h exp=0", readData); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_wait_stray_rsp_stall got=%b exp=0", stall); end
    push_exp(1'b1, 3'b001, 64'h7102, 64'h0, 64'h0000_0000_F00F_0000, 0, 0);
    do_access("after_reset_lh", 1'b1, 1'b0, 3'b001, 64'h7102, 64'h0, 64'h0000_0000_F00F_0000, 0, 0);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_ld();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
